uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Serial receiver matching the 9600-baud periodic temperature-report link: recovers
//   8N2 frames from an asynchronous line and assembles consecutive bytes into one
//   OUTPUT_DATA_WIDTH-bit word. Sits at the board's UART RX pin; used for loopback
//   checks of the transmit path and for host-to-board commands.
// PARAMETERS
//   BAUD_2_CLOCK_RATIO  1250  clk cycles per bit (12 MHz / 9600)
//   UART_DATA_BITS      8     data bits per frame, LSB first, no parity
//   UART_STOP_BITS      2     stop bits per frame, all must be 1
//   OUTPUT_DATA_WIDTH   16    word width; must be a multiple of UART_DATA_BITS
//   WORD_TIMEOUT_BITS   20    max idle bit-times between bytes of one word
// PORTS
//   clk         in   1                  system clock (12 MHz)
//   rst         in   1                  asynchronous reset, active high
//   rx          in   1                  serial line, idle high, asynchronous to clk
//   data_out    out  OUTPUT_DATA_WIDTH  last complete word; holds until next word
//   data_valid  out  1                  1-cycle pulse: data_out updated this cycle
//   frame_err   out  1                  1-cycle pulse: stop bit sampled low
//   busy        out  1                  high from start-bit detect to end of last stop bit
// BEHAVIOUR
// - Reset (async, active high): all outputs 0; FSM IDLE; counters, byte index and
//   shift register cleared; synchroniser flops set to 1 (idle). Reset mid-frame aborts
//   the frame and any partial word; no data_valid/frame_err pulse.
// - rx passes a 2-flop synchroniser; all decisions use the synchronised value rxs.
// - FSM: IDLE -> START -> DATA -> STOP -> IDLE; BREAK for framing-error recovery.
//   IDLE : rxs==0 -> START, bit counter loaded with BAUD_2_CLOCK_RATIO/2 - 1; busy=1.
//   START: at count 0 resample; rxs==1 -> false start, back to IDLE, busy=0, no pulse;
//          rxs==0 -> DATA, counter reloaded with BAUD_2_CLOCK_RATIO-1.
//   DATA : sample at each count 0 (mid-bit), shift in LSB first; after
//          UART_DATA_BITS samples -> STOP.
//   STOP : sample UART_STOP_BITS times at mid-bit. All 1 -> byte accepted, IDLE.
//          Any 0 -> frame_err pulse on the cycle after that sample, byte and partial
//          word discarded, -> BREAK.
//   BREAK: wait for rxs==1 for one full bit period, then IDLE; busy stays 1.
// - busy falls on the cycle the FSM re-enters IDLE.
// - Word assembly: first accepted byte of a word -> data_out bits [7:0], next ->
//   [15:8] (generally byte k -> [8k+7:8k]). Assembly is in an internal register;
//   data_out changes only on completion.
// - data_valid: asserted the cycle after the final stop-bit sample of the word's last
//   byte; data_out loaded in the same cycle. Exactly one pulse per word.
// - Inter-byte timeout: after a byte accepted with the word incomplete, a timer counts
//   clk cycles in IDLE; reaching WORD_TIMEOUT_BITS*BAUD_2_CLOCK_RATIO discards the
//   partial word silently (byte index -> 0). A start bit clears the timer.
// - A false start neither resets nor discards the partial word; timer continues.
// - Counters width $clog2 of their max values; no wrap in normal operation.
// TESTING
// - Send 0x34 then 0x12, 8N2, 1250 clk/bit, 2-bit gap -> one data_valid,
//   data_out=16'h1234, frame_err never high, busy low after last stop bit.
// - 300-clk low glitch on idle rx -> no busy change past START, no pulses, data_out
//   unchanged; following 0xCD,0xAB -> data_out=16'hABCD.
// - Byte 0x55 with second stop bit forced 0 -> frame_err single pulse; then 0x01,0x02
//   -> data_out=16'h0201 (corrupt byte not used as low byte).
// - Send 0x77, idle 21 bit-times, send 0x11,0x22 -> one data_valid, data_out=16'h2211.
// - Assert rst for 3 cycles mid DATA of the second byte -> outputs 0 immediately
//   (asynchronously); next full word 0xEF,0xBE -> data_out=16'hBEEF.
// - Back-to-back words 0x0000 and 0xFFFF, zero gap -> two data_valid pulses
//   2 frames apart, values 16'h0000 then 16'hFFFF.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N2 asynchronous serial receiver that packs consecutive bytes into one word.
// Latency: data_valid/frame_err pulse one clk after the last stop-bit mid-sample.
// Backpressure: none; the line cannot be stalled, so each word is presented once.
// Ports:
//   clk        - system clock
//   rst        - asynchronous reset, active high
//   rx         - serial line, idle high, asynchronous to clk
//   data_out   - last complete word, held until the next word completes
//   data_valid - one-cycle pulse when data_out is updated
//   frame_err  - one-cycle pulse when a stop bit is sampled low
//   busy       - high while a frame (or break recovery) is in progress
module uart_rx #(
  parameter int BAUD_2_CLOCK_RATIO = 1250,
  parameter int UART_DATA_BITS     = 8,
  parameter int UART_STOP_BITS     = 2,
  parameter int OUTPUT_DATA_WIDTH  = 16,
  parameter int WORD_TIMEOUT_BITS  = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx,
  output logic [OUTPUT_DATA_WIDTH-1:0] data_out,
  output logic                         data_valid,
  output logic                         frame_err,
  output logic                         busy
);

  localparam int NBYTES      = OUTPUT_DATA_WIDTH / UART_DATA_BITS;
  localparam int CNT_W       = $clog2(BAUD_2_CLOCK_RATIO);
  localparam int MAX_BITS    = (UART_DATA_BITS > UART_STOP_BITS) ? UART_DATA_BITS : UART_STOP_BITS;
  localparam int BIT_W       = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int BYTE_W      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TIMEOUT_CYC = WORD_TIMEOUT_BITS * BAUD_2_CLOCK_RATIO;
  localparam int TMO_W       = $clog2(TIMEOUT_CYC);

  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(BAUD_2_CLOCK_RATIO / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BAUD_2_CLOCK_RATIO - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(UART_DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(UART_STOP_BITS - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                       state_q, state_d;
  logic                         rx_meta_q, rx_meta_d;
  logic                         rxs_q, rxs_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [BIT_W-1:0]             bit_q, bit_d;
  logic [UART_DATA_BITS-1:0]    shift_q, shift_d;
  logic [BYTE_W-1:0]            byte_idx_q, byte_idx_d;
  logic [OUTPUT_DATA_WIDTH-1:0] word_q, word_d;
  logic [TMO_W-1:0]             timer_q, timer_d;
  logic [OUTPUT_DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                         data_valid_q, data_valid_d;
  logic                         frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    rx_meta_d    = rx;
    rxs_d        = rx_meta_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    timer_d      = timer_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    // Inter-byte timeout runs only while a partial word is pending and no
    // confirmed frame is in flight; a false start does not pause or clear it.
    if ((byte_idx_q != '0) && ((state_q == S_IDLE) || (state_q == S_START))) begin
      if (timer_q == TMO_LAST) begin
        timer_d    = '0;
        byte_idx_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = CNT_HALF;
        end
      end

      S_START: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = CNT_FULL;
            bit_d   = '0;
            timer_d = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rxs_q, shift_q[UART_DATA_BITS-1:1]};
          cnt_d   = CNT_FULL;
          if (bit_q == LAST_DATA) begin
            state_d = S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_FULL;
          if (!rxs_q) begin
            frame_err_d = 1'b1;
            byte_idx_d  = '0;
            state_d     = S_BREAK;
          end else if (bit_q == LAST_STOP) begin
            // Byte accepted; the last byte of a word publishes the whole word.
            word_d[byte_idx_q*UART_DATA_BITS +: UART_DATA_BITS] = shift_q;
            timer_d = '0;
            state_d = S_IDLE;
            if (byte_idx_q == LAST_BYTE) begin
              data_out_d   = word_d;
              data_valid_d = 1'b1;
              byte_idx_d   = '0;
            end else begin
              byte_idx_d = byte_idx_q + 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_BREAK: begin
        // Require one uninterrupted bit period of idle line before re-arming.
        if (!rxs_q) begin
          cnt_d = CNT_FULL;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      timer_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rxs_q        <= rxs_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      timer_q      <= timer_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a shortened bit period.
// Each scenario task drives the serial line and checks outputs inline.
// A negedge monitor counts data_valid/frame_err pulses and captures words.
module tb_uart_rx;

  localparam int B = 16;  // clk cycles per bit in this bench

  logic        clk;
  logic        rst;
  logic        rx;
  logic [15:0] data_out;
  logic        data_valid;
  logic        frame_err;
  logic        busy;

  int          errors = 0;
  int          checks = 0;

  int          cyc = 0;
  int          vld_n = 0;
  int          ferr_n = 0;
  int          last_cyc = 0;
  int          prev_cyc = 0;
  logic [15:0] last_word = 16'h0;
  logic [15:0] first_word = 16'h0;

  uart_rx #(
    .BAUD_2_CLOCK_RATIO(B),
    .UART_DATA_BITS(8),
    .UART_STOP_BITS(2),
    .OUTPUT_DATA_WIDTH(16),
    .WORD_TIMEOUT_BITS(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data_out(data_out),
    .data_valid(data_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (data_valid === 1'b1) begin
      vld_n     = vld_n + 1;
      first_word = last_word;
      last_word = data_out;
      prev_cyc  = last_cyc;
      last_cyc  = cyc;
    end
    if (frame_err === 1'b1) ferr_n = ferr_n + 1;
  end

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * B) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop2);
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (B) @(negedge clk);
    end
    rx = 1'b1;
    repeat (B) @(negedge clk);
    rx = bad_stop2 ? 1'b0 : 1'b1;
    repeat (B) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_data_out got=%h exp=0000", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    idle_bits(2);
  endtask

  task automatic test_basic;
    int v0, f0;
    v0 = vld_n; f0 = ferr_n;
    send_byte(8'h34, 1'b0);
    idle_bits(2);
    send_byte(8'h12, 1'b0);
    @(negedge clk);
    checks++; if (vld_n - v0 !== 1) begin errors++; $display("FAIL basic_valid_count got=%0d exp=1", vld_n - v0); end
    checks++; if (last_word !== 16'h1234) begin errors++; $display("FAIL basic_word got=%h exp=1234", last_word); end
    checks++; if (ferr_n !== f0) begin errors++; $display("FAIL basic_frame_err got=%0d exp=0", ferr_n - f0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    idle_bits(2);
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = vld_n; f0 = ferr_n;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle_bits(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got=%b exp=0", busy); end
    checks++; if (vld_n !== v0) begin errors++; $display("FAIL glitch_valid got=%0d exp=0", vld_n - v0); end
    checks++; if (ferr_n !== f0) begin errors++; $display("FAIL glitch_frame_err got=%0d exp=0", ferr_n - f0); end
    checks++; if (data_out !== 16'h1234) begin errors++; $display("FAIL glitch_data_out got=%h exp=1234", data_out); end
    send_byte(8'hCD, 1'b0);
    send_byte(8'hAB, 1'b0);
    idle_bits(1);
    checks++; if (vld_n - v0 !== 1) begin errors++; $display("FAIL glitch_after_count got=%0d exp=1", vld_n - v0); end
    checks++; if (last_word !== 16'hABCD) begin errors++; $display("FAIL glitch_after_word got=%h exp=abcd", last_word); end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = vld_n; f0 = ferr_n;
    send_byte(8'h55, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_in_break got=%b exp=1", busy); end
    idle_bits(2);
    checks++; if (ferr_n - f0 !== 1) begin errors++; $display("FAIL ferr_pulses got=%0d exp=1", ferr_n - f0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_recovered got=%b exp=0", busy); end
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    idle_bits(1);
    checks++; if (vld_n - v0 !== 1) begin errors++; $display("FAIL ferr_valid_count got=%0d exp=1", vld_n - v0); end
    checks++; if (last_word !== 16'h0201) begin errors++; $display("FAIL ferr_word got=%h exp=0201", last_word); end
    checks++; if (ferr_n - f0 !== 1) begin errors++; $display("FAIL ferr_no_extra got=%0d exp=1", ferr_n - f0); end
  endtask

  task automatic test_timeout;
    int v0;
    v0 = vld_n;
    send_byte(8'h77, 1'b0);
    idle_bits(21);
    checks++; if (vld_n !== v0) begin errors++; $display("FAIL timeout_partial_valid got=%0d exp=0", vld_n - v0); end
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    idle_bits(1);
    checks++; if (vld_n - v0 !== 1) begin errors++; $display("FAIL timeout_valid_count got=%0d exp=1", vld_n - v0); end
    checks++; if (last_word !== 16'h2211) begin errors++; $display("FAIL timeout_word got=%h exp=2211", last_word); end
  endtask

  task automatic test_rst_mid;
    int v0;
    send_byte(8'h5A, 1'b0);
    // Second byte: start bit plus three data bits, then reset lands mid DATA.
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      repeat (B) @(negedge clk);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before got=%b exp=1", busy); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL rst_async_data_out got=%h exp=0000", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_bits(3);
    v0 = vld_n;
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    idle_bits(1);
    checks++; if (vld_n - v0 !== 1) begin errors++; $display("FAIL rst_valid_count got=%0d exp=1", vld_n - v0); end
    checks++; if (last_word !== 16'hBEEF) begin errors++; $display("FAIL rst_word got=%h exp=beef", last_word); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = vld_n;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFF, 1'b0);
    idle_bits(1);
    checks++; if (vld_n - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count got=%0d exp=2", vld_n - v0); end
    checks++; if (first_word !== 16'h0000) begin errors++; $display("FAIL b2b_first_word got=%h exp=0000", first_word); end
    checks++; if (last_word !== 16'hFFFF) begin errors++; $display("FAIL b2b_second_word got=%h exp=ffff", last_word); end
    checks++; if (last_cyc - prev_cyc !== 22 * B) begin errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", last_cyc - prev_cyc, 22 * B); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_after got=%b exp=0", busy); end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_timeout();
    test_rst_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
